// File: rtl/or1200_cl_pad_pkg.sv
// Shared definitions for the cache-line pad applicator.
//
// Contents:
//   state_e    - line FSM encoding (IDLE=0, WAIT_PAD=1, STREAM=2, DRAIN=3)
//   LINE_WORDS - words per cache line (two 128-bit pads cover exactly one line)
//   WORD_W     - data word width
//   PAD_W      - width of the concatenated pad buffer {enc_pad_1, enc_pad_2}
//   pad_slice  - returns the 32-bit pad slice used by word idx
package or1200_cl_pad_pkg;

  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned PAD_W      = 256;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitPad = 2'd1,
    StStream  = 2'd2,
    StDrain   = 2'd3
  } state_e;

  // Word k takes pad[PAD_W-1-WORD_W*k -: WORD_W], so word 0 gets the MSBs of enc_pad_1.
  function automatic logic [WORD_W-1:0] pad_slice(input logic [PAD_W-1:0] pad,
                                                  input logic [2:0]       idx);
    logic [PAD_W-1:0] shifted;
    int unsigned      sh;
    sh      = WORD_W * 32'(idx);
    shifted = pad << sh;
    return shifted[PAD_W-1 -: WORD_W];
  endfunction

endpackage

// File: rtl/or1200_cl_pad_outreg.sv
// Single-entry valid/ready output register slice.
//
// Holds one word and its valid flag. A new word is loaded when load_i is high; the upstream
// logic only asserts load_i when the slice is empty or being drained in the same cycle, so
// no word is overwritten. While valid_o is high and out_ready_i is low the word is held.
//
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset, invalidates and zeroes the slice
//   load_i       - capture data_i this cycle
//   data_i       - word to capture
//   out_ready_i  - downstream accepts the held word
//   valid_o      - slice holds a valid word
//   data_o       - held word
module or1200_cl_pad_outreg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             out_ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/or1200_cl_pad_xor.sv
// Cache-line pad applicator.
//
// Captures the two 128-bit AES pads from the encryption top when enc_done is seen with no
// pad held, then XORs them word by word onto an 8-word cache-line burst. XOR is symmetric,
// so the same path encrypts write-backs and decrypts refills. When secure_exec is low at
// line_start the line passes through unchanged and the held pad is left untouched.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   secure_exec    - secure mode, sampled at line_start and held for the line
//   enc_done       - enc_pad_1/enc_pad_2 valid this cycle
//   enc_pad_1/2    - pads for words 0-3 / 4-7
//   line_start     - opens a new line burst (ignored outside IDLE)
//   word_valid_i, word_i, word_ready_o - input word handshake
//   word_valid_o, word_o, word_ready_i - output word handshake (1-cycle latency)
//   line_done_o    - pulse while the 8th word is accepted downstream
//   busy_o         - FSM not in IDLE
//
// Configuration macro: OR1200_CL_PAD_CLEAR_EN
//   defined   - pad buffer is zeroized on reset and on secure line completion
//   undefined - only the pad valid flag is cleared; buffer contents persist
module or1200_cl_pad_xor #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              secure_exec,
  input  logic              enc_done,
  input  logic [127:0]      enc_pad_1,
  input  logic [127:0]      enc_pad_2,
  input  logic              line_start,
  input  logic              word_valid_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              word_ready_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  input  logic              word_ready_i,
  output logic              line_done_o,
  output logic              busy_o
);

  import or1200_cl_pad_pkg::*;

  localparam logic [2:0] LastWord = 3'(LINE_WORDS - 1);

  state_e             state_q, state_d;
  logic [2:0]         wcnt_q, wcnt_d;
  logic               pad_valid_q, pad_valid_d;
  logic               secure_q, secure_d;
  logic [PAD_W-1:0]   pad_q, pad_d;

  logic               pad_load;
  logic               in_accept;
  logic               out_fire;
  logic               line_end;
  logic [WORD_W-1:0]  pad_word;
  logic [WORD_W-1:0]  xor_word;

  // A pad arriving while one is still held belongs to nobody and is dropped.
  assign pad_load     = enc_done && !pad_valid_q;
  assign word_ready_o = (state_q == StStream) && (!word_valid_o || word_ready_i);
  assign in_accept    = word_ready_o && word_valid_i;
  assign out_fire     = word_valid_o && word_ready_i;
  // In DRAIN the output slice can only hold the last word of the line.
  assign line_end     = (state_q == StDrain) && out_fire;
  assign line_done_o  = line_end;
  assign busy_o       = (state_q != StIdle);

  // Non-secure lines see an all-zero pad, giving a pure pass-through.
  assign pad_word = secure_q ? pad_slice(pad_q, wcnt_q) : '0;
  assign xor_word = word_i ^ pad_word;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    secure_d = secure_q;
    unique case (state_q)
      StIdle: begin
        if (line_start) begin
          secure_d = secure_exec;
          wcnt_d   = '0;
          // A pad captured in this very cycle counts, so no WAIT_PAD bubble is inserted.
          if (!secure_exec || pad_valid_q || enc_done) begin
            state_d = StStream;
          end else begin
            state_d = StWaitPad;
          end
        end
      end
      StWaitPad: begin
        if (pad_valid_q || pad_load) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (in_accept) begin
          wcnt_d = wcnt_q + 3'd1;
          if (wcnt_q == LastWord) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pad_valid_d = pad_valid_q;
    pad_d       = pad_q;
    if (pad_load) begin
      pad_valid_d = 1'b1;
      pad_d       = {enc_pad_1, enc_pad_2};
    end
    // Only a secure line consumes the pad.
    if (line_end && secure_q) begin
      pad_valid_d = 1'b0;
`ifdef OR1200_CL_PAD_CLEAR_EN
      pad_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wcnt_q      <= '0;
      pad_valid_q <= 1'b0;
      secure_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pad_valid_q <= pad_valid_d;
      secure_q    <= secure_d;
    end
  end

`ifdef OR1200_CL_PAD_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_q <= '0;
    end else begin
      pad_q <= pad_d;
    end
  end
`else
  // Contents are only ever read after a load, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    pad_q <= pad_d;
  end
`endif

  or1200_cl_pad_outreg #(
    .Width(WORD_W)
  ) u_outreg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (in_accept),
    .data_i     (xor_word),
    .out_ready_i(word_ready_i),
    .valid_o    (word_valid_o),
    .data_o     (word_o)
  );

endmodule

// File: tb/tb_or1200_cl_pad_xor.sv
module tb_or1200_cl_pad_xor;

  logic         clk = 1'b0;
  logic         rst;
  logic         secure_exec;
  logic         enc_done;
  logic [127:0] enc_pad_1;
  logic [127:0] enc_pad_2;
  logic         line_start;
  logic         word_valid_i;
  logic [31:0]  word_i;
  logic         word_ready_o;
  logic         word_valid_o;
  logic [31:0]  word_o;
  logic         word_ready_i;
  logic         line_done_o;
  logic         busy_o;

  or1200_cl_pad_xor #(
    .LINE_WORDS(8),
    .WORD_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .secure_exec (secure_exec),
    .enc_done    (enc_done),
    .enc_pad_1   (enc_pad_1),
    .enc_pad_2   (enc_pad_2),
    .line_start  (line_start),
    .word_valid_i(word_valid_i),
    .word_i      (word_i),
    .word_ready_o(word_ready_o),
    .word_valid_o(word_valid_o),
    .word_o      (word_o),
    .word_ready_i(word_ready_i),
    .line_done_o (line_done_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [31:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // order: 0 pad first, 1 line first (5 cycles), 2 pad and line_start together,
  //        3 reuse a pad that is already held
  typedef struct {
    int           order;
    bit           sec;
    bit           junk;
    bit           ls_at_done;
    int           stall;
    logic [127:0] p1;
    logic [127:0] p2;
    logic [31:0]  seed;
    logic [31:0]  step;
    logic [31:0]  exp_w0;
  } line_vec_t;

  line_vec_t vecs[7];

  function automatic line_vec_t mk(input int order, input bit sec, input bit junk,
                                   input bit ls_at_done, input int stall,
                                   input logic [127:0] p1, input logic [127:0] p2,
                                   input logic [31:0] seed, input logic [31:0] step,
                                   input logic [31:0] exp_w0);
    line_vec_t v;
    v.order = order; v.sec = sec; v.junk = junk; v.ls_at_done = ls_at_done;
    v.stall = stall; v.p1 = p1; v.p2 = p2; v.seed = seed; v.step = step;
    v.exp_w0 = exp_w0;
    return v;
  endfunction

  function automatic logic [31:0] slice(input logic [255:0] p, input int k);
    return p[255 - 32*k -: 32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && word_valid_o) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h with nothing outstanding", word_o);
      end else if (word_ready_i) begin
        check("word_out", word_o, sb_q.pop_front());
      end else begin
        check("hold_word", word_o, sb_q[0]);
        check("hold_ready_o", 32'(word_ready_o), 32'd0);
      end
    end
  end

  task automatic pulse_enc(input logic [127:0] p1, input logic [127:0] p2);
    enc_done = 1'b1; enc_pad_1 = p1; enc_pad_2 = p2;
    @(posedge clk); #1;
    enc_done = 1'b0;
  endtask

  // Drives one word and pushes its expected result at the negedge before it is accepted.
  task automatic send_word(input logic [31:0] w, input logic [31:0] e, output int acc_cyc);
    int n;
    n = 0;
    word_valid_i = 1'b1;
    word_i       = w;
    @(negedge clk);
    while (!word_ready_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!word_ready_o) check("accept_timeout", 32'(word_ready_o), 32'd1);
    else sb_q.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic run_line(input line_vec_t v);
    logic [255:0] pad;
    logic [31:0]  w;
    logic [31:0]  e;
    int           acc0;
    int           acc;
    int           n;
    pad = {v.p1, v.p2};
    acc0 = 0;
    if (v.order == 0) pulse_enc(v.p1, v.p2);
    if (v.junk) pulse_enc(~v.p1, ~v.p2);
    secure_exec = v.sec;
    line_start  = 1'b1;
    if (v.order == 2) begin
      enc_done = 1'b1; enc_pad_1 = v.p1; enc_pad_2 = v.p2;
    end
    @(posedge clk); #1;
    line_start  = 1'b0;
    enc_done    = 1'b0;
    secure_exec = ~v.sec;  // must be ignored for the rest of the line
    @(negedge clk);
    check("ready_after_start", 32'(word_ready_o), (v.order == 1) ? 32'd0 : 32'd1);
    check("busy_after_start", 32'(busy_o), 32'd1);
    if (v.order == 1) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_pad_ready", 32'(word_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      enc_done = 1'b1; enc_pad_1 = v.p1; enc_pad_2 = v.p2;
      @(negedge clk);
      check("capture_cycle_ready", 32'(word_ready_o), 32'd0);
      @(posedge clk); #1;
      enc_done = 1'b0;
      @(negedge clk);
      check("ready_after_capture", 32'(word_ready_o), 32'd1);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      w = v.seed + v.step * 32'(k);
      e = (k == 0) ? v.exp_w0 : (w ^ (v.sec ? slice(pad, k) : 32'd0));
      send_word(w, e, acc);
      if (k == 0) acc0 = acc;
      if (k == v.stall) begin
        word_ready_i = 1'b0;
        word_i       = v.seed + v.step * 32'(k + 1);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_ready_o", 32'(word_ready_o), 32'd0);
          @(posedge clk); #1;
        end
        word_ready_i = 1'b1;
      end
    end
    word_valid_i = 1'b0;
    if (v.ls_at_done) line_start = 1'b1;
    n = 0;
    @(negedge clk);
    while (!line_done_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("line_done_seen", 32'(line_done_o), 32'd1);
    check("line_done_latency", 32'(cyc - acc0), (v.stall >= 0) ? 32'd11 : 32'd8);
    @(posedge clk); #1;
    line_start = 1'b0;
    @(negedge clk);
    check("line_done_pulse", 32'(line_done_o), 32'd0);
    check("idle_after_line", 32'(busy_o), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [31:0] w;
    vecs[0] = mk(0, 1, 0, 0, -1, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 32'hA5A5_A5A5, 32'h0,
                 32'hA486_E0C2);
    vecs[1] = mk(1, 1, 0, 1, -1, 128'h0000_0001_0000_0002_0000_0003_0000_0004,
                 128'h1000_0000_2000_0000_3000_0000_4000_0000, 32'h1111_0000, 32'h1,
                 32'h1111_0001);
    vecs[2] = mk(0, 1, 0, 0, 2, 128'hDEAD_BEEF_CAFE_BABE_0BAD_F00D_FEED_FACE,
                 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 32'h0, 32'h0101_0101,
                 32'hDEAD_BEEF);
    vecs[3] = mk(2, 1, 0, 0, -1, {4{32'h5555_5555}}, {4{32'hAAAA_AAAA}},
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    vecs[4] = mk(0, 0, 0, 0, -1, {4{32'h0F0F_0F0F}}, {4{32'hF0F0_F0F0}},
                 32'h1234_5678, 32'h3, 32'h1234_5678);
    vecs[5] = mk(3, 1, 1, 0, -1, {4{32'h0F0F_0F0F}}, {4{32'hF0F0_F0F0}},
                 32'h0, 32'h0, 32'h0F0F_0F0F);
    vecs[6] = mk(0, 1, 0, 0, -1, 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_3210,
                 128'h0, 32'h8000_0000, 32'h1, 32'h9357_9BDF);

    rst = 1'b1; secure_exec = 1'b0; enc_done = 1'b0; enc_pad_1 = '0; enc_pad_2 = '0;
    line_start = 1'b0; word_valid_i = 1'b0; word_i = '0; word_ready_i = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_word_ready_o", 32'(word_ready_o), 32'd0);
    check("rst_word_valid_o", 32'(word_valid_o), 32'd0);
    check("rst_word_o", word_o, 32'd0);
    check("rst_line_done_o", 32'(line_done_o), 32'd0);
    check("rst_busy_o", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_line(vecs[i]);

    // Reset in the middle of a secure line, after word 4 has been accepted.
    pulse_enc({4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}});
    secure_exec = 1'b1;
    line_start  = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = 32'(k);
      send_word(w, ~w, acc);
    end
    word_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_word_ready_o", 32'(word_ready_o), 32'd0);
    check("midrst_word_valid_o", 32'(word_valid_o), 32'd0);
    check("midrst_word_o", word_o, 32'd0);
    check("midrst_line_done_o", 32'(line_done_o), 32'd0);
    check("midrst_busy_o", 32'(busy_o), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;

    run_line(vecs[6]);
`ifdef OR1200_CL_PAD_CLEAR_EN
    check("pad_cleared", 32'(dut.pad_q == '0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
